// File: rtl/ifetch_pkg.sv
// ifetch_pkg: shared state encodings and constants for the instruction fetch unit
package ifetch_pkg;
    typedef enum logic [1:0] {IDLE, REQ, DRAIN, VALID} state_t;
    localparam logic [31:0] FAULT_WORD = 32'h0;
    localparam logic [1:0]  ALIGN_MASK = 2'b11;
endpackage

// File: rtl/ifetch_unit_if.sv
// ifetch_unit_if: instruction-memory bus plus the fetched-instruction stream
interface ifetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        imem_err;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_out;
    logic [31:0] inst_pc;
    logic        inst_fault;
    modport master (
        output imem_req, imem_addr, inst_valid, inst_out, inst_pc, inst_fault,
        input  imem_ack, imem_rdata, imem_err, inst_ready
    );
    modport slave (
        input  imem_req, imem_addr, inst_valid, inst_out, inst_pc, inst_fault,
        output imem_ack, imem_rdata, imem_err, inst_ready
    );
endinterface

// File: rtl/ifetch_unit.sv
// ifetch_unit: single-entry instruction fetch buffer with flush/drain handling.
// Advances the external PC register only on a delivered (handshaked) entry.
module ifetch_unit
    import ifetch_pkg::*;
#(
    parameter int RESET_WAIT = 1,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      pc_in,
    output logic             pc_ena,
    input  logic             flush,
    output logic [CNT_W-1:0] fetch_count,
    ifetch_unit_if.master    bus
);
    state_t      state;
    logic [31:0] wait_cnt;
    logic [31:0] addr_q;
    logic        aligned;
    logic        hs;
    assign aligned        = (pc_in[1:0] & ALIGN_MASK) == 2'b00;
    assign bus.inst_valid = state == VALID && !flush;
    assign hs             = bus.inst_valid && bus.inst_ready;
    assign pc_ena         = hs;
    assign bus.imem_req   = (state == REQ && aligned) || state == DRAIN;
    // in REQ the address follows pc_in; addr_q keeps it for a drain after flush
    assign bus.imem_addr  = state == REQ ? pc_in : addr_q;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= IDLE;
            wait_cnt       <= '0;
            addr_q         <= '0;
            bus.inst_out   <= '0;
            bus.inst_pc    <= '0;
            bus.inst_fault <= 1'b0;
            fetch_count    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (flush || wait_cnt + 32'd1 >= 32'(RESET_WAIT)) state <= REQ;
                    else wait_cnt <= wait_cnt + 32'd1;
                end
                REQ: begin
                    addr_q <= pc_in;
                    if (flush) begin
                        state <= (aligned && !bus.imem_ack) ? DRAIN : REQ;
                    end else if (!aligned) begin
                        state          <= VALID;
                        bus.inst_out   <= FAULT_WORD;
                        bus.inst_pc    <= pc_in;
                        bus.inst_fault <= 1'b1;
                    end else if (bus.imem_ack) begin
                        state          <= VALID;
                        bus.inst_out   <= bus.imem_err ? FAULT_WORD : bus.imem_rdata;
                        bus.inst_pc    <= pc_in;
                        bus.inst_fault <= bus.imem_err;
                    end
                end
                DRAIN: if (bus.imem_ack) state <= REQ;
                VALID: begin
                    if (flush) begin
                        state <= REQ;
                    end else if (hs) begin
                        state       <= REQ;
                        fetch_count <= fetch_count + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ifetch_unit.sv
// tb_ifetch_unit: directed scenario tests for ifetch_unit with hand-computed expectations
module tb_ifetch_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] pc_in = '0;
    logic        pc_ena;
    logic        flush = 1'b0;
    logic [3:0]  fetch_count;
    int          n_cmp = 0;
    int          n_bad = 0;
    int          pena_cnt = 0;
    int          req_cnt = 0;
    logic        dead_seen = 1'b0;
    int          pe0;
    int          rc0;

    ifetch_unit_if bus ();

    ifetch_unit #(.RESET_WAIT(1), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .pc_in(pc_in), .pc_ena(pc_ena), .flush(flush),
        .fetch_count(fetch_count), .bus(bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (pc_ena) pena_cnt++;
        if (bus.imem_req) req_cnt++;
        if (bus.inst_valid && bus.inst_out == 32'hDEADBEEF) dead_seen = 1'b1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        bus.imem_ack = 0; bus.imem_rdata = '0; bus.imem_err = 0; bus.inst_ready = 1;
        step(); step();
        n_cmp++; if (bus.imem_req !== 1'b0) begin n_bad++; $display("FAIL rst_req: got %b want 0", bus.imem_req); end
        n_cmp++; if (bus.imem_addr !== 32'h0) begin n_bad++; $display("FAIL rst_addr: got %h want 0", bus.imem_addr); end
        n_cmp++; if (bus.inst_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid: got %b want 0", bus.inst_valid); end
        n_cmp++; if ({bus.inst_out, bus.inst_pc, bus.inst_fault} !== 65'h0) begin n_bad++; $display("FAIL rst_entry: got %h %h %b want 0", bus.inst_out, bus.inst_pc, bus.inst_fault); end
        n_cmp++; if (fetch_count !== 4'h0) begin n_bad++; $display("FAIL rst_count: got %h want 0", fetch_count); end
        n_cmp++; if (pc_ena !== 1'b0) begin n_bad++; $display("FAIL rst_pcena: got %b want 0", pc_ena); end
        bus.inst_ready = 0;
        rst = 1;
        #1;
        n_cmp++; if (bus.imem_req !== 1'b0) begin n_bad++; $display("FAIL idle_req: got %b want 0", bus.imem_req); end
    endtask

    task automatic test_basic;
        pe0 = pena_cnt;
        step();
        n_cmp++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0) begin n_bad++; $display("FAIL basic_req: got %b %h want 1 00000000", bus.imem_req, bus.imem_addr); end
        step();
        n_cmp++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0) begin n_bad++; $display("FAIL basic_hold: got %b %h want 1 00000000", bus.imem_req, bus.imem_addr); end
        step();
        bus.imem_ack = 1; bus.imem_rdata = 32'h20080005; bus.inst_ready = 1;
        step();
        bus.imem_ack = 0;
        #1;
        n_cmp++; if (bus.inst_valid !== 1'b1 || bus.inst_out !== 32'h20080005) begin n_bad++; $display("FAIL basic_out: got %b %h want 1 20080005", bus.inst_valid, bus.inst_out); end
        n_cmp++; if (bus.inst_pc !== 32'h0 || bus.inst_fault !== 1'b0) begin n_bad++; $display("FAIL basic_pc: got %h %b want 0 0", bus.inst_pc, bus.inst_fault); end
        n_cmp++; if (pc_ena !== 1'b1) begin n_bad++; $display("FAIL basic_pcena: got %b want 1", pc_ena); end
        step();
        bus.inst_ready = 0; pc_in = 32'h4;
        #1;
        n_cmp++; if (fetch_count !== 4'd1) begin n_bad++; $display("FAIL basic_count: got %0d want 1", fetch_count); end
        n_cmp++; if (pena_cnt - pe0 !== 1) begin n_bad++; $display("FAIL basic_pulses: got %0d want 1", pena_cnt - pe0); end
    endtask

    task automatic test_hold;
        bus.imem_ack = 1; bus.imem_rdata = 32'h11111111;
        step();
        bus.imem_ack = 0;
        pe0 = pena_cnt;
        for (int i = 0; i < 5; i++) begin
            #1;
            n_cmp++; if (bus.inst_valid !== 1'b1 || bus.inst_out !== 32'h11111111 || bus.inst_pc !== 32'h4) begin n_bad++; $display("FAIL hold_entry[%0d]: got %b %h %h want 1 11111111 00000004", i, bus.inst_valid, bus.inst_out, bus.inst_pc); end
            n_cmp++; if (pc_ena !== 1'b0) begin n_bad++; $display("FAIL hold_pcena[%0d]: got %b want 0", i, pc_ena); end
            step();
        end
        bus.inst_ready = 1;
        #1;
        n_cmp++; if (pc_ena !== 1'b1) begin n_bad++; $display("FAIL hold_release: got %b want 1", pc_ena); end
        step();
        bus.inst_ready = 0; pc_in = 32'h8;
        #1;
        n_cmp++; if (pena_cnt - pe0 !== 1 || fetch_count !== 4'd2) begin n_bad++; $display("FAIL hold_pulses: got %0d cnt %0d want 1 cnt 2", pena_cnt - pe0, fetch_count); end
    endtask

    task automatic test_flush_drain;
        #1;
        n_cmp++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h8) begin n_bad++; $display("FAIL drain_req: got %b %h want 1 00000008", bus.imem_req, bus.imem_addr); end
        step();
        flush = 1;
        step();
        pc_in = 32'h40;
        #1;
        n_cmp++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h8) begin n_bad++; $display("FAIL drain_addr: got %b %h want 1 00000008", bus.imem_req, bus.imem_addr); end
        step();
        flush = 0; bus.imem_ack = 1; bus.imem_rdata = 32'hDEADBEEF;
        #1;
        n_cmp++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h8) begin n_bad++; $display("FAIL drain_reflush: got %b %h want 1 00000008", bus.imem_req, bus.imem_addr); end
        step();
        bus.imem_ack = 0;
        #1;
        n_cmp++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h40) begin n_bad++; $display("FAIL drain_next: got %b %h want 1 00000040", bus.imem_req, bus.imem_addr); end
        n_cmp++; if (bus.inst_valid !== 1'b0 || fetch_count !== 4'd2) begin n_bad++; $display("FAIL drain_state: got %b cnt %0d want 0 cnt 2", bus.inst_valid, fetch_count); end
        bus.imem_ack = 1; bus.imem_rdata = 32'h22222222;
        step();
        bus.imem_ack = 0;
        #1;
        n_cmp++; if (bus.inst_out !== 32'h22222222 || bus.inst_pc !== 32'h40) begin n_bad++; $display("FAIL drain_refetch: got %h %h want 22222222 00000040", bus.inst_out, bus.inst_pc); end
        bus.inst_ready = 1;
        step();
        bus.inst_ready = 0; pc_in = 32'h6;
        #1;
        n_cmp++; if (dead_seen !== 1'b0 || fetch_count !== 4'd3) begin n_bad++; $display("FAIL drain_discard: got seen %b cnt %0d want 0 cnt 3", dead_seen, fetch_count); end
    endtask

    task automatic test_misaligned;
        pe0 = pena_cnt; rc0 = req_cnt;
        #1;
        n_cmp++; if (bus.imem_req !== 1'b0) begin n_bad++; $display("FAIL mis_req: got %b want 0", bus.imem_req); end
        step();
        n_cmp++; if (bus.inst_valid !== 1'b1 || bus.inst_fault !== 1'b1 || bus.inst_out !== 32'h0 || bus.inst_pc !== 32'h6) begin n_bad++; $display("FAIL mis_entry: got %b %b %h %h want 1 1 0 6", bus.inst_valid, bus.inst_fault, bus.inst_out, bus.inst_pc); end
        bus.inst_ready = 1;
        step();
        bus.inst_ready = 0; pc_in = 32'hC;
        #1;
        n_cmp++; if (pena_cnt - pe0 !== 1 || req_cnt !== rc0 || fetch_count !== 4'd4) begin n_bad++; $display("FAIL mis_advance: got pulses %0d reqs %0d cnt %0d want 1 0 4", pena_cnt - pe0, req_cnt - rc0, fetch_count); end
    endtask

    task automatic test_err_wrap;
        bus.imem_ack = 1; bus.imem_err = 1; bus.imem_rdata = 32'hFFFFFFFF;
        step();
        bus.imem_ack = 0; bus.imem_err = 0;
        #1;
        n_cmp++; if (bus.inst_fault !== 1'b1 || bus.inst_out !== 32'h0 || bus.inst_pc !== 32'hC) begin n_bad++; $display("FAIL err_entry: got %b %h %h want 1 0 c", bus.inst_fault, bus.inst_out, bus.inst_pc); end
        bus.inst_ready = 1;
        step();
        bus.inst_ready = 0;
        for (int i = 0; i < 10; i++) begin
            bus.imem_ack = 1; bus.imem_rdata = 32'(i);
            step();
            bus.imem_ack = 0; bus.inst_ready = 1;
            step();
            bus.inst_ready = 0;
        end
        #1;
        n_cmp++; if (fetch_count !== 4'd15) begin n_bad++; $display("FAIL wrap_pre: got %0d want 15", fetch_count); end
        bus.imem_ack = 1;
        step();
        bus.imem_ack = 0; bus.inst_ready = 1;
        step();
        bus.inst_ready = 0;
        #1;
        n_cmp++; if (fetch_count !== 4'd0) begin n_bad++; $display("FAIL wrap_zero: got %0d want 0", fetch_count); end
    endtask

    task automatic test_flush_valid;
        bus.imem_ack = 1; bus.imem_rdata = 32'hAAAA5555;
        step();
        bus.imem_rdata = 32'h12345678;
        step();
        bus.imem_ack = 0;
        #1;
        n_cmp++; if (bus.inst_valid !== 1'b1 || bus.inst_out !== 32'hAAAA5555) begin n_bad++; $display("FAIL ack_ignored: got %b %h want 1 aaaa5555", bus.inst_valid, bus.inst_out); end
        pe0 = pena_cnt;
        flush = 1; bus.inst_ready = 1;
        #1;
        n_cmp++; if (pc_ena !== 1'b0 || bus.inst_valid !== 1'b0) begin n_bad++; $display("FAIL flush_valid_comb: got %b %b want 0 0", pc_ena, bus.inst_valid); end
        step();
        flush = 0; bus.inst_ready = 0;
        #1;
        n_cmp++; if (bus.inst_valid !== 1'b0 || bus.imem_req !== 1'b1 || fetch_count !== 4'd0 || pena_cnt !== pe0) begin n_bad++; $display("FAIL flush_valid_next: got %b %b cnt %0d pulses %0d want 0 1 0 0", bus.inst_valid, bus.imem_req, fetch_count, pena_cnt - pe0); end
    endtask

    task automatic test_flush_ack;
        bus.imem_ack = 1; flush = 1; bus.imem_rdata = 32'h33333333;
        step();
        bus.imem_ack = 0; flush = 0;
        #1;
        n_cmp++; if (bus.inst_valid !== 1'b0 || bus.imem_req !== 1'b1 || bus.imem_addr !== 32'hC) begin n_bad++; $display("FAIL flush_ack: got %b %b %h want 0 1 0000000c", bus.inst_valid, bus.imem_req, bus.imem_addr); end
    endtask

    task automatic test_reset_mid;
        bus.inst_ready = 1;
        rst = 0;
        #1;
        n_cmp++; if (bus.imem_req !== 1'b0 || bus.imem_addr !== 32'h0 || bus.inst_valid !== 1'b0 || pc_ena !== 1'b0) begin n_bad++; $display("FAIL mid_rst_ctl: got %b %h %b %b want 0 0 0 0", bus.imem_req, bus.imem_addr, bus.inst_valid, pc_ena); end
        n_cmp++; if ({bus.inst_out, bus.inst_pc, bus.inst_fault} !== 65'h0 || fetch_count !== 4'h0) begin n_bad++; $display("FAIL mid_rst_entry: got %h %h %b cnt %0d want 0", bus.inst_out, bus.inst_pc, bus.inst_fault, fetch_count); end
        step(); step();
        rst = 1; bus.inst_ready = 0;
        #1;
        n_cmp++; if (bus.imem_req !== 1'b0) begin n_bad++; $display("FAIL mid_idle: got %b want 0", bus.imem_req); end
        step();
        n_cmp++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'hC) begin n_bad++; $display("FAIL mid_restart: got %b %h want 1 0000000c", bus.imem_req, bus.imem_addr); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_hold();
        test_flush_drain();
        test_misaligned();
        test_err_wrap();
        test_flush_valid();
        test_flush_ack();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/ifetch_unit.md
IFETCH_UNIT -- requirements
Module: ifetch_unit

Interface
REQ-001 Parameter RESET_WAIT, default 1: cycles spent in IDLE after reset release before the first request.
REQ-002 Parameter CNT_W, default 16: width of the fetch counter.
REQ-003 clk  in  1  single clock; all state changes on rising edge.
REQ-004 rst  in  1  asynchronous, active-low reset; rst=0 forces reset state immediately.
REQ-005 pc_in  in  32  current PC, driven by the PC register output.
REQ-006 pc_ena  out  1  enable to the PC register; high for exactly the cycles in which it must load its next value.
REQ-007 imem_req  out  1  instruction-memory read request.
REQ-008 imem_addr  out  32  word address of the request.
REQ-009 imem_ack  in  1  memory completion strobe, one cycle per request.
REQ-010 imem_rdata  in  32  read data, valid with imem_ack.
REQ-011 imem_err  in  1  bus error, valid with imem_ack.
REQ-012 flush  in  1  discard the buffered or in-flight instruction.
REQ-013 inst_valid  out  1  instruction buffer holds a deliverable entry.
REQ-014 inst_ready  in  1  downstream accepts the entry.
REQ-015 inst_out  out  32  buffered instruction word.
REQ-016 inst_pc  out  32  PC of the buffered entry.
REQ-017 inst_fault  out  1  entry is a fault: misaligned PC or bus error.
REQ-018 fetch_count  out  CNT_W  number of delivered entries, wrapping.

Function
REQ-019 States SHALL be IDLE, REQ, DRAIN and VALID.
REQ-020 IDLE SHALL last RESET_WAIT cycles and then go to REQ.
REQ-021 REQ with pc_in[1:0]!=0: no request is issued; the next cycle is VALID with inst_fault=1, inst_out=0 and inst_pc=pc_in.
REQ-022 REQ with an aligned PC: imem_req=1 and imem_addr=pc_in, both held stable until imem_ack.
REQ-023 imem_ack in REQ SHALL capture imem_rdata into inst_out, pc_in into inst_pc and imem_err into inst_fault, then go to VALID. When imem_err=1, inst_out=0.
REQ-024 VALID SHALL drive inst_valid=1 and hold the buffered entry until the handshake.
REQ-025 Handshake in VALID: inst_valid and inst_ready both high. That cycle pc_ena=1 (combinational), fetch_count increments (wrapping at 2^CNT_W), and the next state is REQ.
REQ-026 Minimum request-to-request spacing SHALL be 2 cycles: ack cycle, then handshake cycle.
REQ-027 pc_ena SHALL be 0 in every cycle without a handshake; faults are handshaked and advance the PC like normal entries.
REQ-028 Flush has priority over every other event. It drops inst_valid, forces pc_ena=0 and does not increment fetch_count.
REQ-029 Flush in VALID or IDLE goes to REQ.
REQ-030 Flush in REQ with imem_ack the same cycle discards the data and goes to REQ.
REQ-031 Flush in REQ without imem_ack goes to DRAIN, with imem_req held until the ack.
REQ-032 DRAIN: imem_req=1 with the original address. On imem_ack, the data is discarded and the next state is REQ, which fetches the new pc_in.
REQ-033 Flush while already in DRAIN has no further effect.
REQ-034 imem_ack outside REQ/DRAIN SHALL be ignored.

Reset
REQ-035 On rst=0: state=IDLE, imem_req=0, imem_addr=0, inst_valid=0, inst_out=0, inst_pc=0, inst_fault=0, fetch_count=0.
REQ-036 pc_ena SHALL be 0 while rst=0.
REQ-037 Reset asserted mid-request abandons it without waiting for imem_ack.

Structure
REQ-038 State encodings SHALL live in the shared package ifetch_pkg, alongside the fault-word constant 32'h0 and the alignment-mask constant 2'b11.
REQ-039 The block is a single module with no sub-modules; the instruction buffer, FSM and counter are inline.

Verification
REQ-040 Reset released, pc_in=0x00000000, memory acks 2 cycles after the request with 0x20080005, inst_ready=1 -> imem_addr=0x0, inst_out=0x20080005, inst_pc=0x0, one pc_ena pulse, fetch_count=1.
REQ-041 pc_in=0x00000006 -> imem_req never asserted; inst_valid=1 with inst_fault=1 and inst_out=0; after the handshake, pc_ena pulses once.
REQ-042 Entry at pc 0x4 with inst_ready=0 for 5 cycles -> inst_valid and inst_out stable, pc_ena=0 throughout; inst_ready=1 -> a single pc_ena pulse.
REQ-043 Flush 1 cycle after the request to 0x8, ack at cycle 3 with 0xDEADBEEF, pc_in changed to 0x40 -> DRAIN, 0xDEADBEEF never presented, next request address 0x40, fetch_count unchanged.
REQ-044 Ack with imem_err=1 -> inst_fault=1, inst_out=0; with CNT_W=4, after 16 handshakes fetch_count wraps to 0.
REQ-045 rst=0 while imem_req=1 -> all outputs at reset values immediately; after release, the first request occurs after RESET_WAIT cycles.
